// File: rtl/lif_if.sv
// Handshake bundle for the LIF neuron array:
// sample input channel and registered result channel.
interface lif_if #(
  parameter int W  = 8,
  parameter int CW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ch;
  logic [W-1:0]  in_current;
  logic [W-1:0]  threshold;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ch;
  logic [W-1:0]  out_state;
  logic          out_spike;

  modport slave (
    input  in_valid, in_ch, in_current,
    input  threshold, out_ready,
    output in_ready, out_valid, out_ch,
    output out_state, out_spike
  );

  modport master (
    output in_valid, in_ch, in_current,
    output threshold, out_ready,
    input  in_ready, out_valid, out_ch,
    input  out_state, out_spike
  );
endinterface

// File: rtl/lif_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons
// sharing one update datapath and one result register.
module lif_array #(
  parameter int NUM_CH     = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT    = 2,
  parameter int RESET_MODE = 0,
  parameter int CW         = $clog2(NUM_CH)
) (
  input  logic  clk,
  input  logic  reset_n,
  lif_if.slave  bus
);

  localparam int RW =
    (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [RW-1:0] REF_V = RW'(REFRACT);

  logic [W-1:0]  state_q [NUM_CH];
  logic [RW-1:0] rcnt_q  [NUM_CH];

  logic          ov_q, ov_d;
  logic [CW-1:0] och_q, och_d;
  logic [W-1:0]  ost_q, ost_d;
  logic          osp_q, osp_d;

  logic          acc;
  logic          in_range;
  logic          hit;
  logic [CW-1:0] ch_idx;
  logic [W-1:0]  s;
  logic [RW-1:0] r;
  logic [W-1:0]  leaked;
  logic [W:0]    sum_w;
  logic [W-1:0]  sum;
  logic          refr;
  logic          fire;
  logic [W-1:0]  new_st;
  logic [RW-1:0] new_r;

  // Power-of-two arrays have no unreachable indices.
  if (NUM_CH == (1 << CW)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (bus.in_ch < CW'(NUM_CH));
  end

  assign bus.in_ready  = !ov_q || bus.out_ready;
  assign bus.out_valid = ov_q;
  assign bus.out_ch    = och_q;
  assign bus.out_state = ost_q;
  assign bus.out_spike = osp_q;

  assign acc    = bus.in_valid && bus.in_ready;
  assign hit    = acc && in_range;
  assign ch_idx = hit ? bus.in_ch : '0;

  always_comb begin
    s      = state_q[ch_idx];
    r      = rcnt_q[ch_idx];
    leaked = s - (s >> LEAK_SHIFT);
    sum_w  = {1'b0, leaked} + {1'b0, bus.in_current};
    sum    = sum_w[W] ? '1 : sum_w[W-1:0];
    refr   = (r != '0);
    fire   = !refr && (sum >= bus.threshold);
    new_st = sum;
    new_r  = '0;
    unique case (1'b1)
      refr: begin
        new_st = leaked;
        new_r  = r - 1'b1;
      end
      fire: begin
        new_st = (RESET_MODE != 0) ?
                 sum - bus.threshold : '0;
        new_r  = REF_V;
      end
      default: ;
    endcase
  end

  always_comb begin
    ov_d  = ov_q;
    och_d = och_q;
    ost_d = ost_q;
    osp_d = osp_q;
    if (hit) begin
      ov_d  = 1'b1;
      och_d = bus.in_ch;
      ost_d = new_st;
      osp_d = fire;
    end else if (bus.out_ready) begin
      ov_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ov_q  <= 1'b0;
      och_q <= '0;
      ost_q <= '0;
      osp_q <= 1'b0;
    end else begin
      ov_q  <= ov_d;
      och_q <= och_d;
      ost_q <= ost_d;
      osp_q <= osp_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= '0;
        rcnt_q[i]  <= '0;
      end
    end else if (hit) begin
      state_q[ch_idx] <= new_st;
      rcnt_q[ch_idx]  <= new_r;
    end
  end

endmodule

// File: tb/tb_lif_array.sv
// Bench: two arrays (zero-reset/4ch, subtract-reset/3ch)
// driven in lockstep against per-array scoreboards.
module tb_lif_array;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lif_if #(.W(8), .CW(2)) i0 ();
  lif_if #(.W(8), .CW(2)) i1 ();

  lif_array #(
    .NUM_CH(4), .W(8), .LEAK_SHIFT(1),
    .REFRACT(2), .RESET_MODE(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(i0.slave)
  );

  lif_array #(
    .NUM_CH(3), .W(8), .LEAK_SHIFT(1),
    .REFRACT(2), .RESET_MODE(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(i1.slave)
  );

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] st;
    logic       sp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int passed = 0;
  int total  = 0;
  int st [2][4];
  int rf [2][4];
  logic [7:0] thr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  function automatic exp_t pop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic exp_t model(input int d,
                                 input int ch,
                                 input int cur);
    int s, lk, sum, ns;
    logic sp;
    exp_t e;
    s  = st[d][ch];
    lk = s - (s >> 1);
    sp = 1'b0;
    if (rf[d][ch] > 0) begin
      rf[d][ch]--;
      ns = lk;
    end else begin
      sum = lk + cur;
      if (sum > 255) sum = 255;
      if (sum >= int'(thr)) begin
        sp = 1'b1;
        rf[d][ch] = 2;
        ns = (d == 1) ? sum - int'(thr) : 0;
      end else begin
        ns = sum;
      end
    end
    st[d][ch] = ns;
    e.ch = ch[1:0];
    e.st = ns[7:0];
    e.sp = sp;
    return e;
  endfunction

  task automatic sample(input int d,
                        output logic ov, output logic ir,
                        output logic [1:0] oc,
                        output logic [7:0] os,
                        output logic osp);
    if (d == 0) begin
      ov = i0.out_valid; ir = i0.in_ready;
      oc = i0.out_ch; os = i0.out_state;
      osp = i0.out_spike;
    end else begin
      ov = i1.out_valid; ir = i1.in_ready;
      oc = i1.out_ch; os = i1.out_state;
      osp = i1.out_spike;
    end
  endtask

  task automatic drive(input logic v, input int ch,
                       input int cur, input logic ordy);
    i0.in_valid = v; i1.in_valid = v;
    i0.in_ch = ch[1:0]; i1.in_ch = ch[1:0];
    i0.in_current = cur[7:0];
    i1.in_current = cur[7:0];
    i0.threshold = thr; i1.threshold = thr;
    i0.out_ready = ordy; i1.out_ready = ordy;
  endtask

  // One cycle: check pending result, push accepted work.
  task automatic step(input logic v, input int ch,
                      input int cur, input logic ordy);
    logic ov, ir, osp;
    logic [1:0] oc;
    logic [7:0] os;
    exp_t e;
    logic stall [2];
    exp_t snap [2];
    drive(v, ch, cur, ordy);
    #1;
    for (int d = 0; d < 2; d++) begin
      sample(d, ov, ir, oc, os, osp);
      chk($sformatf("valid%0d", d), 32'(ov),
          32'(qsize(d) != 0));
      stall[d] = 1'b0;
      snap[d]  = '0;
      if (ov === 1'b1 && ordy && qsize(d) != 0) begin
        e = pop(d);
        chk($sformatf("ch%0d", d), 32'(oc), 32'(e.ch));
        chk($sformatf("state%0d", d), 32'(os), 32'(e.st));
        chk($sformatf("spike%0d", d), 32'(osp), 32'(e.sp));
      end else if (ov === 1'b1 && !ordy) begin
        stall[d] = 1'b1;
        snap[d]  = {oc, os, osp};
        chk($sformatf("stall_rdy%0d", d), 32'(ir), 32'd0);
      end
      if (v && ir === 1'b1 && ch < ((d == 0) ? 4 : 3))
        push(d, model(d, ch, cur));
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (stall[d]) begin
        sample(d, ov, ir, oc, os, osp);
        chk($sformatf("hold%0d", d),
            32'({oc, os, osp}), 32'(snap[d]));
      end
    end
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        st[d][c] = 0;
        rf[d][c] = 0;
      end
  endtask

  initial begin
    reset_n = 1'b0;
    thr = 8'd100;
    clear_model();
    drive(1'b0, 0, 0, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(i0.out_valid), 32'd0);
    chk("rst_state", 32'(i0.out_state), 32'd0);
    chk("rst_ch", 32'(i0.out_ch), 32'd0);
    chk("rst_spike", 32'(i0.out_spike), 32'd0);
    chk("rst_ready", 32'(i0.in_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // integrate and fire on ch0
    step(1'b1, 0, 60, 1'b1);
    chk("if_60", 32'(i0.out_state), 32'd60);
    step(1'b1, 0, 60, 1'b1);
    chk("if_90", 32'(i0.out_state), 32'd90);
    step(1'b1, 0, 60, 1'b1);
    chk("if_0", 32'(i0.out_state), 32'd0);
    chk("if_spk", 32'(i0.out_spike), 32'd1);

    // refractory window
    step(1'b1, 0, 60, 1'b1);
    chk("rf_a", 32'(i0.out_state), 32'd0);
    step(1'b1, 0, 60, 1'b1);
    chk("rf_b", 32'(i0.out_state), 32'd0);
    step(1'b1, 0, 60, 1'b1);
    chk("rf_c", 32'(i0.out_state), 32'd60);
    chk("rf_spk", 32'(i0.out_spike), 32'd0);

    // subtract-threshold mode on dut1 ch1
    step(1'b1, 1, 60, 1'b1);
    step(1'b1, 1, 60, 1'b1);
    chk("m1_90", 32'(i1.out_state), 32'd90);
    step(1'b1, 1, 60, 1'b1);
    chk("m1_5", 32'(i1.out_state), 32'd5);
    chk("m1_spk", 32'(i1.out_spike), 32'd1);

    // saturation at threshold 255
    thr = 8'd255;
    step(1'b1, 2, 200, 1'b1);
    chk("sat_200", 32'(i0.out_state), 32'd200);
    step(1'b1, 2, 200, 1'b1);
    chk("sat_0", 32'(i0.out_state), 32'd0);
    chk("sat_spk", 32'(i0.out_spike), 32'd1);

    // threshold 0 always fires
    thr = 8'd0;
    step(1'b1, 3, 0, 1'b1);
    chk("thr0_spk", 32'(i0.out_spike), 32'd1);
    thr = 8'd100;

    // interleave ch0/ch3 with backpressure
    for (int k = 0; k < 9; k++)
      step(1'b1, (k % 2) ? 3 : 0, 30 + k * 7,
           (k % 3) != 1);
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);

    // load nonzero states, leave results pending
    step(1'b1, 0, 20, 1'b1);
    step(1'b1, 1, 20, 1'b1);
    step(1'b1, 3, 20, 1'b1);
    step(1'b1, 2, 20, 1'b0);
    drive(1'b0, 0, 0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_v0", 32'(i0.out_valid), 32'd0);
    chk("mid_s0", 32'(i0.out_state), 32'd0);
    chk("mid_c0", 32'(i0.out_ch), 32'd0);
    chk("mid_p0", 32'(i0.out_spike), 32'd0);
    chk("mid_v1", 32'(i1.out_valid), 32'd0);
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    step(1'b1, 0, 10, 1'b1);
    chk("post_s0", 32'(i0.out_state), 32'd10);
    chk("post_s1", 32'(i1.out_state), 32'd10);

    // out-of-range channel on the 3-channel array
    step(1'b1, 3, 50, 1'b1);
    chk("oor_v1", 32'(i1.out_valid), 32'd0);
    chk("oor_v0", 32'(i0.out_valid), 32'd1);
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
